// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue
//   Instruction fetch stage with a small prefetch queue in front of ID.
//   Owns the fetch PC, issues one word read per cycle to a synchronous
//   (latency 1) instruction memory, and buffers returned words with their
//   PCs in a circular FIFO that ID drains through a valid/ready handshake.
//   A redirect from ID empties the queue and drops the outstanding read in
//   a single cycle.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-low reset
//   imem_req/imem_addr   read request and word address (always the fetch PC)
//   imem_rdata           instruction word, valid the cycle after imem_req
//   redirect_valid/_pc   taken branch / jump target from ID
//   id_ready             ID accepts the head this cycle
//   id_valid/instr/pc    queue head presented to ID
//   PC                   current fetch PC
//   occupancy            number of valid queue entries
module riscv_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,   // power of two, >= 2
  parameter logic [XLEN-1:0] RESET_PC = '0   // word-aligned
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [XLEN-1:0]          id_instr,
  output logic [XLEN-1:0]          id_pc,
  output logic [XLEN-1:0]          PC,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] pc_q,          pc_d;
  logic            inflight_q,    inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [AW-1:0]   rd_ptr_q,      rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [CW-1:0]   count_q,       count_d;
  fq_entry_t       fq_mem_q [DEPTH];

  logic            issue, push, pop;
  logic [CW-1:0]   pending;

  // Only the aligned part of a redirect target is used.
  logic            unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------
  // Credit counts queued entries plus the read still in flight, so a
  // returning word always has a free slot. A same-cycle pop is not counted
  // as credit: that keeps imem_req a function of registers and the two
  // top-level qualifiers only, with no path from id_ready.
  assign pending = count_q + CW'(inflight_q);
  assign issue   = reset & ~redirect_valid & (pending < CW'(DEPTH));
  assign push    = inflight_q & ~redirect_valid;
  assign pop     = id_valid & id_ready & ~redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redirect_valid) begin
      // Flush everything; the word returning next cycle belongs to the
      // wrong path and is dropped by clearing inflight.
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + XLEN'(4);
      end
      // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage carries no reset; entries are only observed while
  // count_q says they are valid. A reset edge also blocks the write so the
  // stale in-flight word can never land in the queue.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      fq_mem_q[wr_ptr_q] <= '{instr: imem_rdata, pc: inflight_pc_q};
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign occupancy = count_q;
  assign id_valid  = (count_q != '0);
  assign id_instr  = fq_mem_q[rd_ptr_q].instr;
  assign id_pc     = fq_mem_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Self-checking bench for riscv_fetch_queue: a queue-level reference model
// is compared against the DUT every cycle, with directed sequences that pin
// literal values, followed by randomized ready / redirect / reset traffic.
module tb_riscv_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] PC;
  logic [2:0]  occupancy;

  // second instance only for the PC wrap-around sequence
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_PC;
  logic [2:0]  w_occ;

  int vectors = 0;
  int errors  = 0;
  bit armed   = 0;

  riscv_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .PC(PC), .occupancy(occupancy)
  );

  riscv_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clock(clock), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_ready(1'b1),
    .id_valid(w_valid), .id_instr(w_instr), .id_pc(w_pc),
    .PC(w_PC), .occupancy(w_occ)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // memory contents: word at address a is 0x1000 + a/4
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  // synchronous memory, latency 1; junk when not requested so any bogus
  // push shows up as a data miscompare
  always @(posedge clock) begin
    if (imem_req) imem_rdata <= memf(imem_addr);
    else          imem_rdata <= $urandom();
  end

  // ---------------- reference model ----------------
  logic [31:0] mpc;
  bit          minfl;
  logic [31:0] minfl_pc;
  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc[$];

  function automatic bit mreq(input bit rst, input bit rv);
    return rst && !rv && ((mq_instr.size() + int'(minfl)) < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input bit rst, input bit rv);
    chk("imem_req",  32'(imem_req), 32'(mreq(rst, rv)));
    chk("imem_addr", imem_addr, mpc);
    chk("PC",        PC, mpc);
    chk("id_valid",  32'(id_valid), 32'(mq_instr.size() != 0));
    chk("occupancy", 32'(occupancy), 32'(mq_instr.size()));
    if (mq_instr.size() != 0) begin
      chk("id_pc",    id_pc, mq_pc[0]);
      chk("id_instr", id_instr, mq_instr[0]);
    end
  endtask

  task automatic model_step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit req;
    req = mreq(rst, rv);
    if (!rst) begin
      mpc = 32'h0; minfl = 0;
      mq_instr.delete(); mq_pc.delete();
    end else if (rv) begin
      mpc = rpc & 32'hFFFF_FFFC; minfl = 0;
      mq_instr.delete(); mq_pc.delete();
    end else begin
      if (rdy && mq_instr.size() != 0) begin
        void'(mq_instr.pop_front());
        void'(mq_pc.pop_front());
      end
      if (minfl) begin
        mq_instr.push_back(memf(minfl_pc));
        mq_pc.push_back(minfl_pc);
      end
      if (req) begin
        minfl = 1; minfl_pc = mpc; mpc = mpc + 32'd4;
      end else begin
        minfl = 0;
      end
    end
  endtask

  // one clock: drive, check combinational+registered outputs, advance model
  task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    #1;
    if (armed) check_model(rst, rv);
    @(posedge clock);
    model_step(rst, rv, rpc, rdy);
    @(negedge clock);
    armed = 1;
  endtask

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    mpc = '0; minfl = 0; minfl_pc = '0;

    // reset
    repeat (3) cycle(0, 0, 0, 1);
    chk("rst_occ",     32'(occupancy), 32'd0);
    chk("rst_valid",   32'(id_valid), 32'd0);
    chk("wrap_rst_pc", w_addr, 32'hFFFF_FFF8);

    // reset release: first fetch at 0, head valid two cycles later
    cycle(1, 0, 0, 1);
    chk("rel_pc1",   PC, 32'd4);
    chk("rel_v1",    32'(id_valid), 32'd0);
    chk("wrap_a1",   w_addr, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 1);
    chk("rel_v2",    32'(id_valid), 32'd1);
    chk("rel_pc2",   id_pc, 32'd0);
    chk("rel_ins2",  id_instr, 32'h1000);
    chk("wrap_a2",   w_addr, 32'h0000_0000);
    cycle(1, 0, 0, 1);
    chk("rel_pc3",   id_pc, 32'd4);
    chk("rel_ins3",  id_instr, 32'h1001);
    chk("rel_occ3",  32'(occupancy), 32'd1);
    chk("wrap_a3",   w_addr, 32'h0000_0004);

    // ID stall: queue saturates, requests stop
    repeat (10) cycle(1, 0, 0, 0);
    chk("stall_occ", 32'(occupancy), 32'd4);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_hd",  id_pc, 32'd4);
    chk("stall_pc",  PC, 32'd20);
    cycle(1, 0, 0, 1);
    chk("unst_occ",  32'(occupancy), 32'd3);
    chk("unst_hd",   id_pc, 32'd8);
    chk("unst_pc",   PC, 32'd20);
    repeat (6) cycle(1, 0, 0, 1);

    // misaligned redirect
    cycle(1, 1, 32'h43, 1);
    chk("mis_occ",   32'(occupancy), 32'd0);
    chk("mis_pc",    PC, 32'h40);
    cycle(1, 0, 0, 1);
    chk("mis_pc2",   PC, 32'h44);
    repeat (3) cycle(1, 0, 0, 1);
    chk("steady_occ", 32'(occupancy), 32'd1);
    chk("steady_hd",  id_pc, 32'h48);

    // redirect with 3 queued + 1 in flight, ready high in redirect cycle
    repeat (2) cycle(1, 0, 0, 0);
    chk("pre_rd_occ", 32'(occupancy), 32'd3);
    cycle(1, 1, 32'h40, 1);
    chk("rd_occ",    32'(occupancy), 32'd0);
    chk("rd_valid",  32'(id_valid), 32'd0);
    cycle(1, 0, 0, 1);
    chk("rd_v1",     32'(id_valid), 32'd0);
    chk("rd_pc1",    PC, 32'h44);
    cycle(1, 0, 0, 1);
    chk("rd_v2",     32'(id_valid), 32'd1);
    chk("rd_hd",     id_pc, 32'h40);
    chk("rd_ins",    id_instr, 32'h1010);

    // mid-run reset with 3 queued + 1 in flight
    repeat (2) cycle(1, 0, 0, 1);
    repeat (2) cycle(1, 0, 0, 0);
    chk("pre_mr_occ", 32'(occupancy), 32'd3);
    cycle(0, 0, 0, 1);
    chk("mr_valid",  32'(id_valid), 32'd0);
    chk("mr_occ",    32'(occupancy), 32'd0);
    chk("mr_pc",     PC, 32'd0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    chk("mr_hd",     id_pc, 32'd0);
    chk("mr_ins",    id_instr, 32'h1000);

    // randomized traffic; ready comes in bursts to exercise saturation
    begin
      bit rdy_mode = 1;
      for (int i = 0; i < 3000; i++) begin
        int r;
        bit rst, rv, rdy;
        r = int'($urandom_range(0, 199));
        rst = (r >= 2);
        rv  = (r >= 2 && r < 12);
        if ($urandom_range(0, 15) == 0) rdy_mode = ~rdy_mode;
        rdy = rdy_mode ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
        cycle(rst, rv, $urandom(), rdy);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_queue.md
# riscv_fetch_queue

Instruction fetch stage with a prefetch queue, sitting directly upstream of the ID stage of `RISCV_Pipeline`. It owns the fetch PC, issues word reads to a synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO. It presents them to ID through a valid/ready handshake. Branches resolved in ID redirect it through a single-cycle flush that discards all queued and in-flight wrong-path instructions.

## Interface
- `XLEN`, default 32: address and instruction width.
- `DEPTH`, default 4: queue entries; must be a power of two and at least 2.
- `RESET_PC`, default 0: first fetch address after reset; must be word-aligned.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; state is cleared on a rising edge while `reset`=0.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  XLEN  word address of the request; equals `PC`.
- `imem_rdata`  in  XLEN  instruction word, valid in the cycle after the `imem_req` cycle (fixed latency of 1).
- `redirect_valid`  in  1  branch taken or jump, from ID.
- `redirect_pc`  in  XLEN  redirect target.
- `id_ready`  in  1  ID accepts an instruction this cycle; 0 means ID is stalled.
- `id_valid`  out  1  the queue head is valid.
- `id_instr`  out  XLEN  instruction at the queue head.
- `id_pc`  out  XLEN  PC of the queue head.
- `PC`  out  XLEN  current fetch PC.
- `occupancy`  out  $clog2(DEPTH)+1  number of valid queue entries.

## Operation
- **State**
  - `PC` register.
  - Circular queue: `DEPTH` entries of {instr, pc}, with read and write pointers and a count.
  - `inflight` flag and `inflight_pc` register: a request is outstanding.
- **Issue rule**
  - `imem_req` = `reset` & ~`redirect_valid` & ((count + `inflight`) < `DEPTH`).
  - A pop in the same cycle does not grant credit, which keeps the full path purely registered.
- **On an issue**
  - `inflight` <= 1.
  - `inflight_pc` <= `PC`.
  - `PC` <= `PC` + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0x00000000).
- **Without an issue** (and no redirect): `inflight` <= 0.
- **Response**
  - If `inflight`=1 and there is no redirect this cycle, {`imem_rdata`, `inflight_pc`} is written at the tail (push).
  - The issue rule guarantees the queue is never written while full.
- **Pop**: on an edge with `id_valid` & `id_ready` and no redirect, the read pointer advances.
- **Count**: count_next = count + push − pop. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo `DEPTH`.
- **Head outputs**
  - `id_valid` = (count != 0).
  - `id_instr` and `id_pc` are driven from the head entry.
  - There is no bypass from `imem_rdata` to ID.
- **Redirect** (highest priority, overrides push and pop):
  - count <= 0 and both pointers <= 0.
  - `inflight` <= 0, so the returning response is dropped.
  - `PC` <= {`redirect_pc`[XLEN-1:2], 2'b00}; misaligned targets are force-aligned.
  - `imem_req`=0 in the redirect cycle.
  - A handshake with `id_ready`=1 in that cycle is not a consumption.
- **Reset** (`reset`=0 on an edge): `PC`=`RESET_PC`, count=0, pointers=0, `inflight`=0.
  - All outputs then read: `id_valid`=0, `occupancy`=0, `imem_req`=0 (combinationally, while `reset`=0).
  - Reset asserted mid-operation has the same effect regardless of queue or in-flight state; the pending response is discarded.
- `id_instr` and `id_pc` are don't-care while `id_valid`=0. The bench must not check them.

## Timing
- **Fetch-to-ID latency**: request in cycle T, data sampled at the end of T+1, `id_valid` high in T+2.
- **First fetch**: the first request (addr `RESET_PC`) occurs in the first cycle with `reset`=1.
- **Redirect penalty**: redirect in cycle N gives a request to the target in N+1, and the target is at the ID head in N+3.
- **Steady state**: with `id_ready`=1 continuously, throughput is one instruction per cycle and occupancy stays at 1.
- **Stall**: with `id_ready`=0, occupancy saturates at `DEPTH` and `imem_req` drops once count + `inflight` = `DEPTH`.
  - Issue resumes in the cycle after the first pop. No instruction is lost or duplicated.
- **Empty queue with `id_ready`=1**: `id_valid`=0 and no pop occurs.

## Test plan
- **Reset release**, memory word i = 0x1000+i: requests go to 0,4,8,… in consecutive cycles. `id_valid` is first high 2 cycles after the first request, with `id_instr`=0x1000 and `id_pc`=0, then one instruction per cycle in order.
- **ID stall**: `id_ready`=0 for 10 cycles → occupancy reaches 4, `imem_req`=0 once saturated. On release, ID receives PCs 0,4,8,12,16,… with no gaps or repeats.
- **Redirect** to 0x40 while the queue holds 3 entries and one request is in flight → occupancy=0 next cycle, and the in-flight word is never presented. The next `id_pc` is 0x40, with `id_valid` high exactly 3 cycles after the redirect cycle.
- **Misaligned redirect** to 0x43 → fetch resumes at 0x40, then 0x44.
- **Wrap-around**: `RESET_PC`=0xFFFFFFF8 → request addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- **Mid-run reset**: `reset` pulsed to 0 for one edge while the queue is full and a request is in flight → `id_valid`=0 and occupancy=0 after that edge. Fetch restarts at `RESET_PC` and the stale in-flight data is never pushed.
